// File: rtl/serial_adder_8_bits.sv
// serial_adder_8_bits: bit-serial ripple adder computing A + B + CIN.
// A single full-adder cell is reused over WIDTH clock cycles, LSB first.
// Each operation is framed by a START / BUSY / DONE handshake.
// The result register (S, COUT and V when present) holds its value until the next operation completes.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow output V.
//
// Handshake semantics:
//   START is sampled only in IDLE or DONE. A sampled START latches A, B and CIN.
//   After that edge, A, B and CIN may change freely.
//   BUSY is high for exactly WIDTH cycles after the accepting edge.
//   DONE is then a one-cycle pulse, and S/COUT are valid from that cycle on.
//   START seen while BUSY is ignored.
//   START held high in the DONE cycle restarts with no idle bubble.
//   RST is synchronous, active-high, and dominates every other event.
//   RST aborts an in-flight operation without producing a DONE pulse.
//
// dbg_state exposes the FSM encoding: 0 = IDLE, 1 = SHIFT, 2 = DONE.
module serial_adder_8_bits #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic [WIDTH-1:0] S,
  output logic             COUT,
  output logic             BUSY,
  output logic             DONE,
  output logic [1:0]       dbg_state
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             V
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             v_q, v_d;
`endif

  // Full-adder cell outputs for the bit currently at the bottom of the shift registers.
  logic sum_bit;
  logic carry_nxt;
  logic accept;

  // Next-state logic: full-adder step, operand shifting, and the START/BUSY/DONE sequencing.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    accept    = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    psum_d  = psum_q;
    s_d     = s_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    v_d     = v_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_d     = A;
          b_d     = B;
          carry_d = CIN;
          cnt_d   = '0;
          psum_d  = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        psum_d  = {sum_bit, psum_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Completing edge: the result register is loaded here and nowhere else.
          s_d     = {sum_bit, psum_q[WIDTH-1:1]};
          cout_d  = carry_nxt;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB cell, and carry_nxt is the carry out of it.
          v_d     = carry_q ^ carry_nxt;
`endif
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers, with synchronous reset taking priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      psum_q  <= psum_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
      v_q     <= v_d;
`endif
    end
  end

  assign S         = s_q;
  assign COUT      = cout_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign dbg_state = state_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign V         = v_q;
`endif

endmodule
